// File: rtl/cell_comm_pkg.sv
// Shared encodings for the cell-comm AXI-Stream packet protocol.
// Used by both the transmit and receive ends.
package cell_comm_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_DATA,
      S_PAD
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_BAD_HEADER,
      ERR_SHORT,
      ERR_LONG
   } err_t;

   localparam logic [31:0] PAD_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/axis_packet_tx_if.sv
// AXI-Stream link between a packet source and the Aurora TX port.
// Master drives valid/last/data, slave drives ready.
interface axis_packet_tx_if;

   logic        TVALID;
   logic        TREADY;
   logic        TLAST;
   logic [31:0] TDATA;

   modport master (
      output TVALID,
      output TLAST,
      output TDATA,
      input  TREADY
   );

   modport slave (
      input  TVALID,
      input  TLAST,
      input  TDATA,
      output TREADY
   );

endinterface

// File: rtl/axis_header_pack.sv
// Combinational header word assembly: magic and index fields, rest zero.
// Shared with the receive side for its expected-header compare.
module axis_header_pack #(
   parameter int MAGIC_WIDTH     = 16,
   parameter int MAGIC_START_BIT = 16,
   parameter int INDEX_WIDTH     = 5,
   parameter int INDEX_START_BIT = 10
) (
   input  logic [MAGIC_WIDTH-1:0] magic,
   input  logic [INDEX_WIDTH-1:0] index,
   output logic [31:0]            header
);

   generate
      if (MAGIC_START_BIT + MAGIC_WIDTH > 32) begin : g_magic_range
         $error("magic field exceeds 32-bit header");
      end
      if (INDEX_START_BIT + INDEX_WIDTH > 32) begin : g_index_range
         $error("index field exceeds 32-bit header");
      end
      if (INDEX_START_BIT < MAGIC_START_BIT + MAGIC_WIDTH &&
          MAGIC_START_BIT < INDEX_START_BIT + INDEX_WIDTH) begin : g_overlap
         $error("index field overlaps magic field");
      end
   endgenerate

   always_comb begin
      header = '0;
      header[MAGIC_START_BIT +: MAGIC_WIDTH] = magic;
      header[INDEX_START_BIT +: INDEX_WIDTH] = index;
   end

endmodule

// File: rtl/axis_packet_tx.sv
// Cell-comm packet transmitter: header plus NUM_DATA_WORDS data words
// over AXI-Stream, with optional bad-header/short/long error injection.
module axis_packet_tx
   import cell_comm_pkg::*;
#(
   parameter int MAGIC_WIDTH     = 16,
   parameter int MAGIC_START_BIT = 16,
   parameter int INDEX_WIDTH     = 5,
   parameter int INDEX_START_BIT = 10,
   parameter int NUM_DATA_WORDS  = 1
) (
   input  logic                        auroraClk,
   input  logic                        auroraReset_n,
   input  logic                        sendStrobe,
   input  logic [INDEX_WIDTH-1:0]      sendIndex,
   input  logic [32*NUM_DATA_WORDS-1:0] sendData,
   input  logic [MAGIC_WIDTH-1:0]      headerMagic,
   input  logic [1:0]                  errInject,
   output logic                        busy,
   output logic                        doneStrobe,
   output logic                        sendOverrun,
   output logic [15:0]                 packetCount,
   axis_packet_tx_if.master            axis
);

   generate
      if (NUM_DATA_WORDS < 1) begin : g_num_words
         $error("NUM_DATA_WORDS must be at least 1");
      end
   endgenerate

   localparam int WCW       = $clog2(NUM_DATA_WORDS + 1);
   localparam int LAST_IDX  = NUM_DATA_WORDS - 1;
   localparam int SHORT_IDX = (NUM_DATA_WORDS > 1) ? NUM_DATA_WORDS - 2 : 0;
   localparam bit HDR_LAST  = (NUM_DATA_WORDS == 1);

   state_t                      state_q, state_d;
   logic [WCW-1:0]              wc_q, wc_d;
   logic [INDEX_WIDTH-1:0]      idx_q;
   logic [32*NUM_DATA_WORDS-1:0] data_q;
   logic [MAGIC_WIDTH-1:0]      magic_q;
   err_t                        err_q;
   logic                        done_q;
   logic                        ovr_q;
   logic [15:0]                 cnt_q;

   logic [MAGIC_WIDTH-1:0] magic_tx;
   logic [31:0]            header;
   logic [31:0]            word;
   logic [31:0]            tdata;
   logic                   tvalid;
   logic                   tlast;
   logic                   at_last;
   logic                   at_short;
   logic                   pkt_end;

   assign magic_tx = (err_q == ERR_BAD_HEADER) ? ~magic_q : magic_q;

   axis_header_pack #(
      .MAGIC_WIDTH     (MAGIC_WIDTH),
      .MAGIC_START_BIT (MAGIC_START_BIT),
      .INDEX_WIDTH     (INDEX_WIDTH),
      .INDEX_START_BIT (INDEX_START_BIT)
   ) u_hdr (
      .magic  (magic_tx),
      .index  (idx_q),
      .header (header)
   );

   always_comb begin
      word = '0;
      for (int j = 0; j < NUM_DATA_WORDS; j++) begin
         if (wc_q == WCW'(j)) word = data_q[32*j +: 32];
      end
   end

   assign at_last  = (wc_q == WCW'(LAST_IDX));
   assign at_short = (wc_q == WCW'(SHORT_IDX));

   always_ff @(posedge auroraClk or negedge auroraReset_n) begin
      if (!auroraReset_n) begin
         state_q <= S_IDLE;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
      end
   end

   // Outputs decode from state so reset drops TVALID without waiting
   // for a clock edge, and stalls hold TDATA/TLAST for free.
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      tvalid  = 1'b0;
      tlast   = 1'b0;
      tdata   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (sendStrobe) begin
               state_d = S_HEADER;
               wc_d    = '0;
            end
         end
         S_HEADER: begin
            tvalid = 1'b1;
            tdata  = header;
            tlast  = (err_q == ERR_SHORT) && HDR_LAST;
            if (axis.TREADY) begin
               state_d = tlast ? S_IDLE : S_DATA;
               wc_d    = '0;
            end
         end
         S_DATA: begin
            tvalid = 1'b1;
            tdata  = word;
            unique case (err_q)
               ERR_SHORT: tlast = at_short;
               ERR_LONG:  tlast = 1'b0;
               default:   tlast = at_last;
            endcase
            if (axis.TREADY) begin
               if (tlast)        state_d = S_IDLE;
               else if (at_last) state_d = S_PAD;
               else              wc_d    = wc_q + WCW'(1);
            end
         end
         S_PAD: begin
            tvalid = 1'b1;
            tdata  = PAD_WORD;
            tlast  = 1'b1;
            if (axis.TREADY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pkt_end = tvalid && axis.TREADY && tlast;

   always_ff @(posedge auroraClk or negedge auroraReset_n) begin
      if (!auroraReset_n) begin
         idx_q   <= '0;
         data_q  <= '0;
         magic_q <= '0;
         err_q   <= ERR_NONE;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done_q <= pkt_end;
         ovr_q  <= sendStrobe && busy;
         if (pkt_end) cnt_q <= cnt_q + 16'd1;
         if (state_q == S_IDLE && sendStrobe) begin
            idx_q   <= sendIndex;
            data_q  <= sendData;
            magic_q <= headerMagic;
            err_q   <= err_t'(errInject);
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign doneStrobe  = done_q;
   assign sendOverrun = ovr_q;
   assign packetCount = cnt_q;
   assign axis.TVALID = tvalid;
   assign axis.TLAST  = tlast;
   assign axis.TDATA  = tdata;

endmodule

// File: tb/tb_axis_packet_tx.sv
// Directed bench for axis_packet_tx: two data-word and one data-word
// instances sharing one clock and reset.
module tb_axis_packet_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic        a_strobe;
   logic [4:0]  a_idx;
   logic [63:0] a_data;
   logic [15:0] a_magic;
   logic [1:0]  a_err;
   logic        a_busy, a_done, a_ovr;
   logic [15:0] a_cnt;

   logic        b_strobe;
   logic [4:0]  b_idx;
   logic [31:0] b_data;
   logic [15:0] b_magic;
   logic [1:0]  b_err;
   logic        b_busy, b_done, b_ovr;
   logic [15:0] b_cnt;

   axis_packet_tx_if ax_a ();
   axis_packet_tx_if ax_b ();

   axis_packet_tx #(.NUM_DATA_WORDS(2)) u_a (
      .auroraClk     (clk),
      .auroraReset_n (rst_n),
      .sendStrobe    (a_strobe),
      .sendIndex     (a_idx),
      .sendData      (a_data),
      .headerMagic   (a_magic),
      .errInject     (a_err),
      .busy          (a_busy),
      .doneStrobe    (a_done),
      .sendOverrun   (a_ovr),
      .packetCount   (a_cnt),
      .axis          (ax_a)
   );

   axis_packet_tx #(.NUM_DATA_WORDS(1)) u_b (
      .auroraClk     (clk),
      .auroraReset_n (rst_n),
      .sendStrobe    (b_strobe),
      .sendIndex     (b_idx),
      .sendData      (b_data),
      .headerMagic   (b_magic),
      .errInject     (b_err),
      .busy          (b_busy),
      .doneStrobe    (b_done),
      .sendOverrun   (b_ovr),
      .packetCount   (b_cnt),
      .axis          (ax_b)
   );

   int compared = 0;
   int mismatched = 0;

   logic [31:0] exp_d [4];
   logic        exp_l [4];
   int          exp_n;

   localparam logic [31:0] HDR   = 32'hA5C31400;
   localparam logic [31:0] HDRB  = 32'h5A3C1400;
   localparam logic [31:0] HDR31 = 32'hA5C37C00;
   localparam logic [31:0] W0    = 32'h11111111;
   localparam logic [31:0] W1    = 32'h22222222;
   localparam logic [31:0] PAD   = 32'hDEADBEEF;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_exp(input int n,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [3:0] l);
      exp_n = n;
      exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
      for (int i = 0; i < 4; i++) exp_l[i] = l[i];
   endtask

   task automatic send(input logic [4:0] idx, input logic [1:0] err);
      a_idx = idx;
      a_err = err;
      a_strobe = 1'b1;
      step();
      a_strobe = 1'b0;
   endtask

   // Checks every presented beat against the expected list, then the
   // end-of-packet cycle; returns in the doneStrobe cycle.
   task automatic collect(input bit rnd, input string tag,
                          input logic [15:0] cnt);
      int idx;
      int cyc;
      logic acc;
      idx = 0;
      cyc = 0;
      while (idx < exp_n && cyc < 200) begin
         chk({tag, "/valid"}, 32'(ax_a.TVALID), 32'd1);
         chk({tag, "/data"}, ax_a.TDATA, exp_d[idx]);
         chk({tag, "/last"}, 32'(ax_a.TLAST), 32'(exp_l[idx]));
         chk({tag, "/busy"}, 32'(a_busy), 32'd1);
         acc = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ax_a.TREADY = acc;
         step();
         if (acc) idx++;
         cyc++;
      end
      ax_a.TREADY = 1'b1;
      chk({tag, "/beats"}, 32'(idx), 32'(exp_n));
      chk({tag, "/end_valid"}, 32'(ax_a.TVALID), 32'd0);
      chk({tag, "/done"}, 32'(a_done), 32'd1);
      chk({tag, "/end_busy"}, 32'(a_busy), 32'd0);
      chk({tag, "/count"}, 32'(a_cnt), 32'(cnt));
   endtask

   initial begin
      a_strobe = 1'b0;
      a_idx = 5'd5;
      a_data = {W1, W0};
      a_magic = 16'hA5C3;
      a_err = 2'd0;
      b_strobe = 1'b0;
      b_idx = 5'd5;
      b_data = 32'h33333333;
      b_magic = 16'hA5C3;
      b_err = 2'd0;
      ax_a.TREADY = 1'b1;
      ax_b.TREADY = 1'b1;

      step();
      step();
      chk("rst/valid", 32'(ax_a.TVALID), 32'd0);
      chk("rst/data", ax_a.TDATA, 32'd0);
      chk("rst/last", 32'(ax_a.TLAST), 32'd0);
      chk("rst/busy", 32'(a_busy), 32'd0);
      chk("rst/done", 32'(a_done), 32'd0);
      chk("rst/ovr", 32'(a_ovr), 32'd0);
      chk("rst/count", 32'(a_cnt), 32'd0);
      rst_n = 1'b1;
      step();

      set_exp(3, HDR, W0, W1, 0, 4'b0100);
      send(5'd5, 2'd0);
      collect(1'b0, "normal", 16'd1);
      step();
      chk("normal/done_pulse", 32'(a_done), 32'd0);

      send(5'd5, 2'd0);
      collect(1'b1, "stall", 16'd2);
      step();

      set_exp(3, HDRB, W0, W1, 0, 4'b0100);
      send(5'd5, 2'd1);
      collect(1'b0, "badhdr", 16'd3);
      step();

      set_exp(2, HDR, W0, 0, 0, 4'b0010);
      send(5'd5, 2'd2);
      collect(1'b0, "short", 16'd4);
      step();

      set_exp(4, HDR, W0, W1, PAD, 4'b1000);
      send(5'd5, 2'd3);
      collect(1'b0, "long", 16'd5);
      step();

      ax_a.TREADY = 1'b0;
      set_exp(3, HDR, W0, W1, 0, 4'b0100);
      send(5'd5, 2'd0);
      a_idx = 5'd9;
      a_data = 64'h4444444433333333;
      a_err = 2'd1;
      a_strobe = 1'b1;
      step();
      a_strobe = 1'b0;
      chk("ovr/pulse", 32'(a_ovr), 32'd1);
      chk("ovr/hold", ax_a.TDATA, HDR);
      step();
      chk("ovr/pulse_end", 32'(a_ovr), 32'd0);
      collect(1'b0, "ovr", 16'd6);

      a_data = {W1, W0};
      set_exp(3, HDR31, W0, W1, 0, 4'b0100);
      send(5'd31, 2'd0);
      collect(1'b0, "b2b", 16'd7);
      step();
      chk("b2b/done_pulse", 32'(a_done), 32'd0);

      send(5'd5, 2'd0);
      step();
      chk("rstmid/word0", ax_a.TDATA, W0);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid/valid", 32'(ax_a.TVALID), 32'd0);
      chk("rstmid/busy", 32'(a_busy), 32'd0);
      chk("rstmid/count", 32'(a_cnt), 32'd0);
      step();
      chk("rstmid/done", 32'(a_done), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rstmid/done2", 32'(a_done), 32'd0);
      set_exp(3, HDR, W0, W1, 0, 4'b0100);
      send(5'd5, 2'd0);
      collect(1'b0, "after_rst", 16'd1);
      step();

      b_err = 2'd2;
      b_strobe = 1'b1;
      step();
      b_strobe = 1'b0;
      chk("n1short/valid", 32'(ax_b.TVALID), 32'd1);
      chk("n1short/data", ax_b.TDATA, HDR);
      chk("n1short/last", 32'(ax_b.TLAST), 32'd1);
      step();
      chk("n1short/end_valid", 32'(ax_b.TVALID), 32'd0);
      chk("n1short/done", 32'(b_done), 32'd1);
      chk("n1short/count", 32'(b_cnt), 32'd1);
      b_err = 2'd0;
      b_strobe = 1'b1;
      step();
      b_strobe = 1'b0;
      chk("n1/hdr", ax_b.TDATA, HDR);
      chk("n1/hdr_last", 32'(ax_b.TLAST), 32'd0);
      step();
      chk("n1/data", ax_b.TDATA, 32'h33333333);
      chk("n1/data_last", 32'(ax_b.TLAST), 32'd1);
      step();
      chk("n1/done", 32'(b_done), 32'd1);
      chk("n1/count", 32'(b_cnt), 32'd2);
      chk("n1/ovr", 32'(b_ovr), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/axis_packet_tx.md
Name: axis_packet_tx

Overview:
- Transmit end of the cell-comm AXI-Stream packet protocol.
- Builds one header word followed by NUM_DATA_WORDS 32-bit data words. Asserts TLAST on the final word and honours TREADY back-pressure.
- Optional error injection produces bad-header, short and long packets, so the downstream packet checker can be exercised in simulation and on hardware loopback.
- Sits on auroraClk between the cell controller (packet source) and the Aurora TX AXIS port.

Parameters:
- MAGIC_WIDTH, 16, header magic field width.
- MAGIC_START_BIT, 16, LSB position of the magic field in the header word.
- INDEX_WIDTH, 5, header index field width.
- INDEX_START_BIT, 10, LSB position of the index field in the header word.
- NUM_DATA_WORDS, 1, number of 32-bit data words per packet (>=1).

Ports:
- auroraClk  in  1  sole clock.
- auroraReset_n  in  1  asynchronous, active-low reset.
- sendStrobe  in  1  one-cycle request to send a packet.
- sendIndex  in  INDEX_WIDTH  index placed in the header.
- sendData  in  32*NUM_DATA_WORDS  payload; word j = sendData[32*j+:32], word 0 sent first.
- headerMagic  in  MAGIC_WIDTH  magic placed in the header.
- errInject  in  2  0 normal, 1 bad header, 2 short, 3 long.
- busy  out  1  packet in progress.
- doneStrobe  out  1  one-cycle pulse after the final beat is accepted.
- sendOverrun  out  1  one-cycle pulse when sendStrobe arrives while busy.
- packetCount  out  16  packets completed, wraps at 2^16.
- TVALID  out  1  AXIS valid.
- TREADY  in  1  AXIS ready.
- TLAST  out  1  AXIS last.
- TDATA  out  32  AXIS data.

Behaviour:
- Reset (asynchronous, auroraReset_n=0): all outputs 0; state S_IDLE; latched registers 0. Reset mid-packet aborts it: TVALID drops immediately and no doneStrobe is issued.
- Header word: magic at MAGIC_START_BIT+:MAGIC_WIDTH; index at INDEX_START_BIT+:INDEX_WIDTH; all other bits 0.
  - errInject=1 sends the bitwise-inverted magic.
- Elaboration-time errors:
  - index field overlapping the magic field;
  - MAGIC_START_BIT+MAGIC_WIDTH>32;
  - NUM_DATA_WORDS<1.
- S_IDLE, on sendStrobe:
  - latch sendIndex, sendData, headerMagic and errInject;
  - busy=1;
  - next cycle TVALID=1 with the header (1-cycle latency); go to S_HEADER.
- AXIS rules:
  - a beat transfers on TVALID&&TREADY;
  - while TVALID&&!TREADY, TDATA/TLAST are held stable;
  - TVALID is never withdrawn before acceptance;
  - TVALID stays continuous between beats of a packet (next word presented the cycle after acceptance).
- S_HEADER, header accepted: go to S_DATA with wordCounter=0.
  - Exception: errInject=2 with NUM_DATA_WORDS=1 puts TLAST on the header itself, and the packet ends.
- S_DATA: presents sendData word wordCounter; on accept wordCounter++.
  - TLAST is set on word NUM_DATA_WORDS-1 (normal and bad-header cases).
  - TLAST is set on word NUM_DATA_WORDS-2 when errInject=2; the packet ends after that word.
  - errInject=3: no TLAST on the last data word; go to S_PAD.
- S_PAD: presents 0xDEADBEEF with TLAST=1; the packet ends on accept.
- Packet end:
  - cycle after the last accept: TVALID=0, busy=0, doneStrobe=1, packetCount+1 (also for injected packets);
  - return to S_IDLE.
- sendStrobe with busy=1: ignored (latched values unchanged); sendOverrun=1 the next cycle.
- sendStrobe in the doneStrobe cycle: accepted (busy is already 0), giving back-to-back packets with 1 idle cycle.
- wordCounter width: $clog2(NUM_DATA_WORDS+1).

Decomposition:
- Shared package cell_comm_pkg:
  - state encodings S_IDLE/S_HEADER/S_DATA/S_PAD;
  - errInject codes ERR_NONE/ERR_BAD_HEADER/ERR_SHORT/ERR_LONG;
  - PAD_WORD=32'hDEADBEEF.
- One sub-module, axis_header_pack: combinational header assembly from magic/index/parameters.
  - Shareable with the receive side for its expected-header compare.

Test Plan:
- Defaults with NUM_DATA_WORDS=2, TREADY=1; magic 0xA5C3, index 5, data {0x22222222,0x11111111}, errInject=0 -> beats 0xA5C31400, 0x11111111, 0x22222222(TLAST); doneStrobe 1 cycle later; packetCount=1.
- Same packet with TREADY toggling 50% random -> identical beat sequence; TDATA/TLAST stable during stalls; no TVALID gaps.
- errInject=1 -> header 0x5A3C1400, then 2 data words with TLAST on the second; errInject=2 -> header, 0x11111111(TLAST); errInject=3 -> header, 2 data words without TLAST, then 0xDEADBEEF(TLAST).
- NUM_DATA_WORDS=1, errInject=2 -> single beat 0xA5C31400 with TLAST; doneStrobe follows.
- sendStrobe mid-packet -> sendOverrun pulse, packet unchanged; sendStrobe in the doneStrobe cycle -> next header TVALID exactly 1 cycle later.
- auroraReset_n low during data word 0 -> TVALID=0 same cycle, no doneStrobe, packetCount=0; after release a new sendStrobe sends a full packet.
